// File: rtl/phi2_bus_timer_if.sv
// CPU-side bus bundle for phi2_bus_timer: decoder/CPU inputs and the generated
// clock, ready, reset and strobe outputs.
interface phi2_bus_timer_if #(
  parameter int NUM_CS = 4,
  parameter int WAIT_W = 3
);
  logic [NUM_CS-1:0]        cs;
  logic [NUM_CS*WAIT_W-1:0] wait_cfg;
  logic                     cpu_rwb;
  logic                     cpu_phi2;
  logic                     cpu_rdy;
  logic                     cpu_resb;
  logic                     phi2_rise;
  logic                     phi2_fall;
  logic                     wr_strobe;

  // Decoder / CPU side: drives selects and direction, observes the timer.
  modport master (
    output cs, wait_cfg, cpu_rwb,
    input  cpu_phi2, cpu_rdy, cpu_resb, phi2_rise, phi2_fall, wr_strobe
  );

  // Timer side.
  modport slave (
    input  cs, wait_cfg, cpu_rwb,
    output cpu_phi2, cpu_rdy, cpu_resb, phi2_rise, phi2_fall, wr_strobe
  );
endinterface

// File: rtl/phi2_bus_timer.sv
// 65C02 phi2 generator with per-chip-select wait states, power-on reset
// stretcher and a write-commit strobe for synchronous memories.
module phi2_bus_timer #(
  parameter int HALF_PERIOD  = 5,
  parameter int NUM_CS       = 4,
  parameter int WAIT_W       = 3,
  parameter int RESET_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  phi2_bus_timer_if.slave   bus
);

  localparam int CNT_W  = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam int RCNT_W = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(HALF_PERIOD - 2);
  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(RESET_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_END = RCNT_W'(RESET_CYCLES - 1);

  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              phi2_q,      phi2_d;
  logic [WAIT_W-1:0] wcnt_q,      wcnt_d;
  logic              stretched_q, stretched_d;
  logic [RCNT_W-1:0] rcnt_q,      rcnt_d;
  logic              resb_q,      resb_d;
  logic              rise_q,      rise_d;
  logic              fall_q,      fall_d;
  logic              wr_q,        wr_d;

  logic              cnt_last;
  logic              rise_evt;
  logic              fall_evt;
  logic              cs_any;
  logic [WAIT_W-1:0] sel_cfg;

  // Lowest set chip select wins.
  always_comb begin
    sel_cfg = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (bus.cs[i]) begin
        sel_cfg = bus.wait_cfg[i*WAIT_W +: WAIT_W];
      end
    end
  end

  assign cs_any   = |bus.cs;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign rise_evt = cnt_last && !phi2_q;
  assign fall_evt = cnt_last && phi2_q;

  // Ready handshake: cpu_rdy=1 means the current phi2 cycle completes at its
  // falling edge; cpu_rdy=0 means the CPU must hold the bus and repeat the
  // cycle. It is decoded only from wcnt, so decoder glitches never reach it.
  always_comb begin
    cnt_d       = cnt_last ? '0 : cnt_q + CNT_W'(1);
    phi2_d      = phi2_q ^ cnt_last;
    rise_d      = rise_evt;
    fall_d      = fall_evt;
    wcnt_d      = wcnt_q;
    stretched_d = stretched_q;
    rcnt_d      = rcnt_q;
    resb_d      = resb_q;

    if (fall_evt && !resb_q) begin
      if (rcnt_q != RCNT_MAX) begin
        rcnt_d = rcnt_q + RCNT_W'(1);
      end
      if (rcnt_q == RCNT_END) begin
        resb_d = 1'b1;
      end
    end

    // The rise after a stall finishes is the completing cycle; skip reload.
    if (rise_evt && resb_q) begin
      if (stretched_q) begin
        stretched_d = 1'b0;
      end else if (cs_any && (wcnt_q == '0)) begin
        wcnt_d = sel_cfg;
      end
    end

    if (fall_evt && (wcnt_q != '0)) begin
      wcnt_d = wcnt_q - WAIT_W'(1);
      if (wcnt_q == WAIT_W'(1)) begin
        stretched_d = 1'b1;
      end
    end

    // Registered one clk early so it lands in the last clk of the high phase.
    wr_d = phi2_q && (cnt_q == CNT_PRE) && (wcnt_q == '0) && cs_any
           && !bus.cpu_rwb && resb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      phi2_q      <= 1'b0;
      wcnt_q      <= '0;
      stretched_q <= 1'b0;
      rcnt_q      <= '0;
      resb_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phi2_q      <= phi2_d;
      wcnt_q      <= wcnt_d;
      stretched_q <= stretched_d;
      rcnt_q      <= rcnt_d;
      resb_q      <= resb_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      wr_q        <= wr_d;
    end
  end

  assign bus.cpu_phi2  = phi2_q;
  assign bus.cpu_rdy   = (wcnt_q == '0);
  assign bus.cpu_resb  = resb_q;
  assign bus.phi2_rise = rise_q;
  assign bus.phi2_fall = fall_q;
  assign bus.wr_strobe = wr_q;

endmodule
